// File: rtl/updown_sweep_ctrl_if.sv
// Host-side control and status bundle for updown_sweep_ctrl.
// The host FSM drives the master side; the sweep controller is the slave side.
interface updown_sweep_ctrl_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CYC_W = 4
);

   // Host requests and run configuration
   logic             start;
   logic             abort;
   logic             hold;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [CYC_W-1:0] cycles;

   // Controller status
   logic [WIDTH-1:0] count;
   logic             mode;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, abort, hold, lo, hi, cycles,
      input  count, mode, busy, done, err
   );

   modport slave (
      input  start, abort, hold, lo, hi, cycles,
      output count, mode, busy, done, err
   );

endinterface

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: ramps count from lo up to hi and back down to lo
// for a programmed number of round trips, then pulses done for one cycle.
// Bounds and round-trip count are latched at start and held for the whole run.
module updown_sweep_ctrl #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CYC_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   updown_sweep_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      StIdle,
      StUp,
      StDown,
      StDone
   } state_e;

   localparam logic [CYC_W-1:0] RemOne = CYC_W'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [CYC_W-1:0] rem_q, rem_d;
   logic             mode_q, mode_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] count_inc;
   logic [WIDTH-1:0] count_dec;
   logic             cfg_ok;

   assign count_inc = count_q + 1'b1;
   assign count_dec = count_q - 1'b1;
   assign cfg_ok    = (bus.lo < bus.hi) && (bus.cycles != '0);

   // Next-state and next-output computation for the sweep sequencer
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mode_d  = mode_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      rem_d   = rem_q;
      err_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            // abort in the same cycle suppresses the start entirely
            if (bus.start && !bus.abort) begin
               if (cfg_ok) begin
                  lo_d    = bus.lo;
                  hi_d    = bus.hi;
                  rem_d   = bus.cycles;
                  count_d = bus.lo;
                  mode_d  = 1'b1;
                  state_d = StUp;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         StUp: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (!bus.hold) begin
               count_d = count_inc;
               // Peak value is shown while already in DOWN
               if (count_inc == hi_q) begin
                  mode_d  = 1'b0;
                  state_d = StDown;
               end
            end
         end

         StDown: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (!bus.hold) begin
               if (count_q == lo_q) begin
                  // Only reachable on the final trough: it has been shown
                  // for one cycle, so finish without moving the count.
                  state_d = StDone;
               end else begin
                  count_d = count_dec;
                  if (count_dec == lo_q) begin
                     rem_d  = rem_q - 1'b1;
                     mode_d = 1'b1;
                     // Intermediate troughs are shown while already in UP
                     if (rem_q != RemOne) begin
                        state_d = StUp;
                     end
                  end
               end
            end
         end

         StDone: begin
            // done is visible for exactly this cycle; start/hold are ignored
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and registered outputs, asynchronously cleared by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         mode_q  <= 1'b1;
         lo_q    <= '0;
         hi_q    <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   // Status decoded directly from registers
   assign bus.count = count_q;
   assign bus.mode  = mode_q;
   assign bus.busy  = (state_q == StUp) || (state_q == StDown);
   assign bus.done  = (state_q == StDone);
   assign bus.err   = err_q;

endmodule
